// File: rtl/lane_generate.sv
// rtl/lane_generate.sv - multi-lane scrolling line generator with LFSR-driven column patterns
// Optional build macro: LANE_SEED_LOAD_EN adds seed_load_i/seed_i for runtime LFSR reseeding.
module lane_generate #(
  parameter int          WIDTH   = 640,
  parameter int          LANES   = 4,
  parameter int          SEG_LEN = 80,
  parameter logic [31:0] SEED    = 32'hACE1_1D3B
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   en_i,
  input  logic [7:0]             density_i,
`ifdef LANE_SEED_LOAD_EN
  input  logic                   seed_load_i,
  input  logic [31:0]            seed_i,
`endif
  output logic [LANES*WIDTH-1:0] line_o,
  output logic [LANES-1:0]       col_o,
  output logic                   new_col_o
);

  localparam int CW = (SEG_LEN > 1) ? $clog2(SEG_LEN) : 1;
  localparam logic [CW-1:0] SEG_LAST = CW'(SEG_LEN - 1);

  logic [CW-1:0]    seg_cnt;
  logic [31:0]      lfsr;
  logic [31:0]      lfsr_next;
  logic             lfsr_fb;
  logic [LANES-1:0] raw;
  logic [LANES-1:0] draw;

  // Fibonacci step for x^32+x^22+x^2+x+1; an all-zero state recovers to SEED.
  always_comb begin
    lfsr_fb   = lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0];
    lfsr_next = {lfsr[30:0], lfsr_fb};
    if (lfsr == 32'h0) begin
      lfsr_next = SEED;
    end
  end

  // Column draw: one LFSR byte per lane against the density threshold, with a forced open lane.
  always_comb begin
    raw = '0;
    for (int k = 0; k < LANES; k++) begin
      raw[k] = (lfsr[8*k +: 8] >= density_i);
    end
    draw = raw;
    if (raw == '0) begin
      draw = '0;
      // Scan high to low so the lowest open lane of the current column wins.
      for (int k = LANES - 1; k >= 0; k--) begin
        if (col_o[k]) begin
          draw    = '0;
          draw[k] = 1'b1;
        end
      end
      if (col_o == '0) begin
        draw[0] = 1'b1;
      end
    end
  end

  // Lane shift registers: each step pushes the current column bit in at bit 0.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      line_o <= '1;
    end else if (en_i) begin
      for (int k = 0; k < LANES; k++) begin
        line_o[k*WIDTH +: WIDTH] <= {line_o[k*WIDTH +: WIDTH-1], col_o[k]};
      end
    end
  end

  // Segment counter, column latch, new-column pulse and free-running LFSR.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      lfsr      <= SEED;
      seg_cnt   <= '0;
      col_o     <= '1;
      new_col_o <= 1'b0;
    end else begin
      new_col_o <= 1'b0;
`ifdef LANE_SEED_LOAD_EN
      if (seed_load_i) begin
        lfsr    <= (seed_i == 32'h0) ? SEED : seed_i;
        seg_cnt <= '0;
      end else
`endif
      begin
        lfsr <= lfsr_next;
        if (en_i) begin
          if (seg_cnt == SEG_LAST) begin
            seg_cnt   <= '0;
            col_o     <= draw;
            new_col_o <= 1'b1;
          end else begin
            seg_cnt <= seg_cnt + CW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_lane_generate.sv
// tb/tb_lane_generate.sv - directed self-checking bench for lane_generate with a reference model
module tb_lane_generate;

  localparam int          W    = 640;
  localparam int          L    = 4;
  localparam int          SEG  = 80;
  localparam logic [31:0] SEED = 32'hACE1_1D3B;

  logic           clk_i = 1'b0;
  logic           reset_i;
  logic           en_i;
  logic [7:0]     density_i;
`ifdef LANE_SEED_LOAD_EN
  logic           seed_load_i;
  logic [31:0]    seed_i;
`endif
  logic [L*W-1:0] line_o;
  logic [L-1:0]   col_o;
  logic           new_col_o;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] m_lane [L];
  logic [L-1:0] m_col;
  logic         m_new;
  logic [31:0]  m_lfsr;
  int           m_seg;

  lane_generate #(.WIDTH(W), .LANES(L), .SEG_LEN(SEG), .SEED(SEED)) dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .en_i       (en_i),
    .density_i  (density_i),
`ifdef LANE_SEED_LOAD_EN
    .seed_load_i(seed_load_i),
    .seed_i     (seed_i),
`endif
    .line_o     (line_o),
    .col_o      (col_o),
    .new_col_o  (new_col_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    if (s == 32'h0) return SEED;
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  function automatic logic [L-1:0] draw_f(input logic [31:0] s, input logic [7:0] d, input logic [L-1:0] c);
    logic [L-1:0] r;
    for (int k = 0; k < L; k++) r[k] = (s[8*k +: 8] >= d);
    if (r != '0) return r;
    if (c == '0) return 4'b0001;
    return c & (~c + 4'b0001);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < L; k++) m_lane[k] = '1;
    m_col  = '1;
    m_new  = 1'b0;
    m_lfsr = SEED;
    m_seg  = 0;
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < L; k++) begin
      checks++;
      assert (line_o[k*W +: W] === m_lane[k]) else begin
        errors++;
        $error("FAIL %s lane%0d observed=%h expected=%h", tag, k, line_o[k*W +: W], m_lane[k]);
      end
    end
    checks++;
    assert (col_o === m_col) else begin
      errors++;
      $error("FAIL %s col_o observed=%h expected=%h", tag, col_o, m_col);
    end
    checks++;
    assert (new_col_o === m_new) else begin
      errors++;
      $error("FAIL %s new_col_o observed=%b expected=%b", tag, new_col_o, m_new);
    end
  endtask

  // One clock: advance the model with the inputs applied at this edge, then compare.
  task automatic cyc(input string tag);
    logic [L-1:0] d;
    @(posedge clk_i);
    if (reset_i) begin
      model_reset();
    end else begin
      d     = draw_f(m_lfsr, density_i, m_col);
      m_new = 1'b0;
      if (en_i) begin
        for (int k = 0; k < L; k++) m_lane[k] = {m_lane[k][W-2:0], m_col[k]};
      end
`ifdef LANE_SEED_LOAD_EN
      if (seed_load_i) begin
        m_lfsr = (seed_i == 32'h0) ? SEED : seed_i;
        m_seg  = 0;
      end else
`endif
      begin
        m_lfsr = lfsr_step(m_lfsr);
        if (en_i) begin
          if (m_seg == SEG - 1) begin
            m_seg = 0;
            m_col = d;
            m_new = 1'b1;
          end else begin
            m_seg++;
          end
        end
      end
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    logic exp_p;
    reset_i   = 1'b1;
    en_i      = 1'b0;
    density_i = 8'h00;
`ifdef LANE_SEED_LOAD_EN
    seed_load_i = 1'b0;
    seed_i      = 32'h0;
`endif
    model_reset();

    // Reset held for three cycles, then ten idle cycles.
    repeat (3) cyc("reset");
    reset_i = 1'b0;
    repeat (10) cyc("hold");
    checks++;
    assert (col_o === 4'hF) else begin errors++; $error("FAIL idle_col observed=%h expected=%h", col_o, 4'hF); end
    checks++;
    assert (line_o === {(L*W){1'b1}}) else begin errors++; $error("FAIL idle_line observed_lo=%h expected all ones", line_o[63:0]); end
    checks++;
    assert (new_col_o === 1'b0) else begin errors++; $error("FAIL idle_new observed=%b expected=0", new_col_o); end

    // Segment timing with density 0: pulses exactly after steps 80 and 160.
    en_i = 1'b1;
    for (int i = 0; i < 160; i++) begin
      cyc("seg_timing");
      exp_p = (i == 79) || (i == 159);
      checks++;
      assert (new_col_o === exp_p) else begin errors++; $error("FAIL seg_pulse step=%0d observed=%b expected=%b", i + 1, new_col_o, exp_p); end
    end
    checks++;
    assert (line_o === {(L*W){1'b1}}) else begin errors++; $error("FAIL dens0_line observed_lo=%h expected all ones", line_o[63:0]); end

    // Pattern insertion at mid density against the model.
    density_i = 8'h80;
    repeat (400) cyc("pattern");

    // Passability at maximum density: never an all-closed column.
    density_i = 8'hFF;
    for (int i = 0; i < 2000; i++) begin
      cyc("pass");
      checks++;
      assert (col_o !== 4'h0) else begin errors++; $error("FAIL pass_col step=%0d observed=%h expected nonzero", i, col_o); end
    end

    // Align to a segment start, then reset asynchronously 37 steps in.
    for (int i = 0; i < 200 && !new_col_o; i++) cyc("align");
    checks++;
    assert (new_col_o === 1'b1) else begin errors++; $error("FAIL align_pulse observed=%b expected=1", new_col_o); end
    repeat (37) cyc("pre_reset");
    #2;
    reset_i = 1'b1;
    #1;
    model_reset();
    check_all("async_reset");
    repeat (2) cyc("reset_hold");
    reset_i   = 1'b0;
    density_i = 8'h80;
    for (int i = 0; i < SEG; i++) begin
      cyc("post_reset");
      exp_p = (i == SEG - 1);
      checks++;
      assert (new_col_o === exp_p) else begin errors++; $error("FAIL restart_pulse step=%0d observed=%b expected=%b", i + 1, new_col_o, exp_p); end
    end

    // Alternating enable: one segment spans 160 cycles.
    for (int j = 0; j < 2 * SEG; j++) begin
      en_i = (j % 2 == 0);
      cyc("toggle");
      exp_p = (j == 2 * SEG - 2);
      checks++;
      assert (new_col_o === exp_p) else begin errors++; $error("FAIL toggle_pulse cycle=%0d observed=%b expected=%b", j, new_col_o, exp_p); end
    end

`ifdef LANE_SEED_LOAD_EN
    // Zero seed falls back to SEED and restarts the segment counter.
    en_i        = 1'b1;
    seed_load_i = 1'b1;
    seed_i      = 32'h0;
    repeat (7) cyc("pre_load");
    seed_load_i = 1'b0;
    for (int i = 0; i < SEG; i++) begin
      cyc("after_load0");
      exp_p = (i == SEG - 1);
      checks++;
      assert (new_col_o === exp_p) else begin errors++; $error("FAIL load0_pulse step=%0d observed=%b expected=%b", i + 1, new_col_o, exp_p); end
    end
    // Explicit seed with enable low, then draws from that seed.
    en_i        = 1'b0;
    seed_load_i = 1'b1;
    seed_i      = 32'h1234_5678;
    cyc("load_seed");
    seed_load_i = 1'b0;
    en_i        = 1'b1;
    repeat (3 * SEG) cyc("after_load");
`endif

    en_i = 1'b0;
    repeat (3) cyc("final_hold");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
